// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch/jump resolution controller with operand-wait stall.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction alive.
module branch_resolve_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [2:0]  i_bop,
    input  logic [1:0]  i_jump,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    input  logic        i_opnd_rdy,
    input  logic [31:0] i_pc4,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_jidx,
    output logic        o_if_stall,
    output logic        o_redirect,
    output logic [31:0] o_target,
    output logic        o_id_flush,
    output logic        o_busy,
    output logic [15:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_OPND = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        is_br;
    logic        is_j;
    logic        is_jr;
    logic        is_ctl;
    logic        needs_opnd;
    logic        br_cond;
    logic        taken;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] tgt_calc;

    logic        stall;
    logic        resolve;
    logic        cnt_inc;

    // A valid branch op shadows whatever the jump class says.
    always_comb begin
        is_br      = (i_bop >= 3'd1) && (i_bop <= 3'd6);
        is_j       = !is_br && (i_jump == 2'b01);
        is_jr      = !is_br && (i_jump == 2'b10);
        is_ctl     = i_valid && (is_br || is_j || is_jr);
        needs_opnd = is_br || is_jr;
    end

    always_comb begin
        br_cond = 1'b0;
        case (i_bop)
            3'd1:    br_cond = (i_rs_val == i_rt_val);
            3'd2:    br_cond = (i_rs_val != i_rt_val);
            3'd3:    br_cond = ($signed(i_rs_val) <= 32'sd0);
            3'd4:    br_cond = ($signed(i_rs_val) >  32'sd0);
            3'd5:    br_cond = ($signed(i_rs_val) <  32'sd0);
            3'd6:    br_cond = ($signed(i_rs_val) >= 32'sd0);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        br_tgt = i_pc4 + {{14{i_imm[15]}}, i_imm, 2'b00};
        j_tgt  = {i_pc4[31:28], i_jidx, 2'b00};
        taken  = is_j || is_jr || (is_br && br_cond);
        if (is_br)
            tgt_calc = br_tgt;
        else if (is_j)
            tgt_calc = j_tgt;
        else
            tgt_calc = i_rs_val;
    end

    // The stall drops in the resolving cycle so decode can advance.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        resolve = 1'b0;
        cnt_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_ctl) begin
                    if (needs_opnd && !i_opnd_rdy) begin
                        stall   = 1'b1;
                        state_d = WAIT_OPND;
                    end else begin
                        resolve = 1'b1;
                        if (taken)
                            state_d = REDIRECT;
                    end
                end
            end
            WAIT_OPND: begin
                cnt_inc = 1'b1;
                if (!i_opnd_rdy) begin
                    stall = 1'b1;
                end else begin
                    resolve = 1'b1;
                    state_d = taken ? REDIRECT : IDLE;
                end
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            o_target    <= 32'd0;
            o_stall_cnt <= 16'd0;
        end else begin
            state_q <= state_d;
            if (resolve && taken)
                o_target <= tgt_calc;
            if (cnt_inc && (o_stall_cnt != 16'hFFFF))
                o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end

    assign o_if_stall = stall && i_rst_n;
    assign o_redirect = (state_q == REDIRECT);
    assign o_busy     = (state_q != IDLE);

`ifdef BRANCH_DELAY_SLOT_EN
    assign o_id_flush = 1'b0;
`else
    assign o_id_flush = (state_q == REDIRECT);
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized checks of branch_resolve_ctrl against a
// behavioural model of branch outcome, target and wait timing.
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [2:0]  bop;
    logic [1:0]  jump;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        opnd_rdy;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic        if_stall;
    logic        redirect;
    logic [31:0] target;
    logic        id_flush;
    logic        busy;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_tgt;
    int          exp_cnt;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit FLUSH_EN = 1'b0;
`else
    localparam bit FLUSH_EN = 1'b1;
`endif

    branch_resolve_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_bop       (bop),
        .i_jump      (jump),
        .i_rs_val    (rs_val),
        .i_rt_val    (rt_val),
        .i_opnd_rdy  (opnd_rdy),
        .i_pc4       (pc4),
        .i_imm       (imm),
        .i_jidx      (jidx),
        .o_if_stall  (if_stall),
        .o_redirect  (redirect),
        .o_target    (target),
        .o_id_flush  (id_flush),
        .o_busy      (busy),
        .o_stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // 0: not control, 1: needs operands (branch/jr), 2: j/jal
    function automatic int ref_class(input logic v, input logic [2:0] b,
                                     input logic [1:0] j);
        if (!v) return 0;
        if (b >= 1 && b <= 6) return 1;
        if (j == 2'b01) return 2;
        if (j == 2'b10) return 1;
        return 0;
    endfunction

    function automatic bit ref_taken(input logic [2:0] b, input logic [1:0] j,
                                     input logic [31:0] rs,
                                     input logic [31:0] rt);
        int s;
        s = rs;
        case (b)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return s <= 0;
            3'd4: return s > 0;
            3'd5: return s < 0;
            3'd6: return s >= 0;
            default: return (j == 2'b01) || (j == 2'b10);
        endcase
    endfunction

    function automatic logic [31:0] ref_target(
        input logic [2:0] b, input logic [1:0] j, input logic [31:0] rs,
        input logic [31:0] p, input logic [15:0] im, input logic [25:0] ji);
        int off;
        logic [31:0] jx;
        if (b >= 1 && b <= 6) begin
            off = int'($signed(im));
            off = off * 4;
            return p + off;
        end
        if (j == 2'b01) begin
            jx = ji;
            return (p & 32'hF000_0000) | (jx * 4);
        end
        return rs;
    endfunction

    task automatic drive(input logic v, input logic [2:0] b,
                         input logic [1:0] j, input logic [31:0] rs,
                         input logic [31:0] rt, input logic rdy,
                         input logic [31:0] p, input logic [15:0] im,
                         input logic [25:0] ji);
        valid = v; bop = b; jump = j; rs_val = rs; rt_val = rt;
        opnd_rdy = rdy; pc4 = p; imm = im; jidx = ji;
    endtask

    task automatic cyc(input string tag, input logic st, input logic bz,
                       input logic rd, input logic [31:0] tg,
                       input int cn);
        @(negedge clk);
        chk({tag, ".stall"}, {31'd0, if_stall}, {31'd0, st});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
        chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, rd});
        chk({tag, ".flush"}, {31'd0, id_flush}, {31'd0, rd & FLUSH_EN});
        chk({tag, ".target"}, target, tg);
        chk({tag, ".cnt"}, {16'd0, stall_cnt}, cn);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic v,
                             input logic [2:0] b, input logic [1:0] j,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] p, input logic [15:0] im,
                             input logic [25:0] ji, input int w_in);
        int cls;
        int w;
        bit tk;
        logic [31:0] tg;
        cls = ref_class(v, b, j);
        w   = (cls == 1) ? w_in : 0;
        tk  = (cls != 0) && ref_taken(b, j, rs, rt);
        tg  = ref_target(b, j, rs, p, im, ji);
        for (int k = 0; k < w; k++) begin
            drive(v, b, j, rs, rt, 1'b0, p, im, ji);
            cyc({tag, ".wait"}, 1'b1, k > 0, 1'b0, exp_tgt,
                exp_cnt + ((k > 0) ? k - 1 : 0));
        end
        drive(v, b, j, rs, rt, (cls == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
              p, im, ji);
        cyc({tag, ".res"}, 1'b0, w > 0, 1'b0, exp_tgt,
            exp_cnt + ((w > 0) ? w - 1 : 0));
        exp_cnt = (exp_cnt + w > 65535) ? 65535 : exp_cnt + w;
        if (tk) begin
            exp_tgt = tg;
            drive(1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom, 16'($urandom), 26'($urandom));
            cyc({tag, ".redir"}, 1'b0, 1'b1, 1'b1, exp_tgt, exp_cnt);
        end
    endtask

    function automatic logic [31:0] pick_rs();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rb;
        logic [1:0]  rj;
        logic [31:0] rrs;
        logic [31:0] rrt;
        exp_tgt = 32'd0;
        exp_cnt = 0;
        rst_n = 1'b0;
        drive(1'b1, 3'd1, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0, 16'd0, 26'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", {31'd0, if_stall}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.redirect", {31'd0, redirect}, 32'd0);
        chk("reset.flush", {31'd0, id_flush}, 32'd0);
        chk("reset.target", target, 32'd0);
        chk("reset.cnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 16'd0, 26'd0);
        cyc("idle", 1'b0, 1'b0, 1'b0, 32'd0, 0);

        run_instr("bne_wait3", 1'b1, 3'd2, 2'b00, 32'd1, 32'd2,
                  32'h0000_2000, 16'hFFFC, 26'd0, 3);
        chk("bne_wait3.cnt_final", {16'd0, stall_cnt}, 32'd3);
        chk("bne_wait3.target_final", target, 32'h0000_1FF0);

        run_instr("beq_taken", 1'b1, 3'd1, 2'b00, 32'd5, 32'd5,
                  32'h0000_0100, 16'h0004, 26'd0, 0);
        chk("beq_taken.target_final", target, 32'h0000_0110);

        run_instr("bgtz_min", 1'b1, 3'd4, 2'b00, 32'h8000_0000, 32'd0,
                  32'h0000_0400, 16'h0010, 26'd0, 0);
        cyc("bgtz_min.after", 1'b0, 1'b0, 1'b0, exp_tgt, exp_cnt);

        run_instr("j_abs", 1'b1, 3'd0, 2'b01, 32'd0, 32'd0,
                  32'hA000_0004, 16'd0, 26'h000_0010, 0);
        chk("j_abs.target_final", target, 32'hA000_0040);

        run_instr("beq_wrap", 1'b1, 3'd1, 2'b00, 32'd9, 32'd9,
                  32'hFFFF_FFFC, 16'h0002, 26'd0, 0);
        chk("beq_wrap.target_final", target, 32'h0000_0004);

        run_instr("jr_low", 1'b1, 3'd0, 2'b10, 32'h1234_5677, 32'd0,
                  32'h0000_0800, 16'd0, 26'd0, 2);

        for (int n = 0; n < 300; n++) begin
            rb  = 3'($urandom_range(0, 7));
            rj  = 2'($urandom_range(0, 3));
            if (rb == 3'd7 && (rj == 2'b01 || rj == 2'b10))
                rj = 2'b00;
            rrs = pick_rs();
            rrt = ($urandom_range(0, 2) == 0) ? rrs : $urandom;
            run_instr($sformatf("rnd%0d", n), $urandom_range(0, 9) != 0,
                      rb, rj, rrs, rrt, $urandom & 32'hFFFF_FFFC,
                      16'($urandom), 26'($urandom), $urandom_range(0, 3));
        end

        drive(1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 16'd0, 26'd0);
        cyc("pre_rst", 1'b0, 1'b0, 1'b0, exp_tgt, exp_cnt);
        drive(1'b1, 3'd0, 2'b10, 32'h0000_4444, 32'd0, 1'b0,
              32'h0000_0100, 16'd0, 26'd0);
        cyc("jr_rst.accept", 1'b1, 1'b0, 1'b0, exp_tgt, exp_cnt);
        rst_n = 1'b0;
        cyc("jr_rst.mid", 1'b0, 1'b1, 1'b0, exp_tgt, exp_cnt);
        exp_tgt = 32'd0;
        exp_cnt = 0;
        chk("jr_rst.stall", {31'd0, if_stall}, 32'd0);
        chk("jr_rst.busy", {31'd0, busy}, 32'd0);
        chk("jr_rst.redirect", {31'd0, redirect}, 32'd0);
        chk("jr_rst.flush", {31'd0, id_flush}, 32'd0);
        chk("jr_rst.target", target, 32'd0);
        chk("jr_rst.cnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 3'd0, 2'b00, 32'd0, 32'd0, 1'b1, 32'd0, 16'd0, 26'd0);
        cyc("jr_rst.post1", 1'b0, 1'b0, 1'b0, 32'd0, 0);
        cyc("jr_rst.post2", 1'b0, 1'b0, 1'b0, 32'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 The block SHALL have these ports: i_clk  in  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have this port: i_rst_n  in  1  reset, synchronous, active-low.
REQ-003 The block SHALL have this port: i_valid  in  1  decode-stage instruction valid this cycle.
REQ-004 The block SHALL have this port: i_bop  in  3  branch op: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
REQ-005 The block SHALL have this port: i_jump  in  2  jump class: 00 none/branch, 01 j/jal, 10 jr, 11 non-control.
REQ-006 The block SHALL have these ports: i_rs_val  in  32  rs operand; i_rt_val  in  32  rt operand; i_opnd_rdy  in  1  both operands final (forwarding resolved).
REQ-007 The block SHALL have these ports: i_pc4  in  32  PC+4 of the decode instruction; i_imm  in  16  branch offset; i_jidx  in  26  jump index.
REQ-008 The block SHALL have these ports: o_if_stall  out  1  hold fetch/decode; o_redirect  out  1  PC redirect pulse; o_target  out  32  redirect PC; o_id_flush  out  1  squash decode-stage instruction; o_busy  out  1  FSM not IDLE; o_stall_cnt  out  16  operand-wait cycle count.

Function
REQ-009 The block SHALL implement FSM states IDLE, WAIT_OPND, REDIRECT.
REQ-010 The block SHALL treat an instruction as control when i_valid=1 and (i_bop in 1..6 or i_jump in {01,10}); i_bop takes precedence over i_jump if both are nonzero.
REQ-011 In IDLE, the block SHALL take a control instruction needing operands (branch or jr) with i_opnd_rdy=0 to WAIT_OPND, with o_if_stall=1 combinationally in that cycle.
REQ-012 In IDLE, the block SHALL resolve a control instruction with operands ready, or any j/jal, in the same cycle: taken -> REDIRECT next cycle; not taken -> stay IDLE, no output change.
REQ-013 In WAIT_OPND, the block SHALL hold o_if_stall=1, increment o_stall_cnt each cycle (saturating at 0xFFFF, no wrap), and resolve per REQ-012 in the first cycle i_opnd_rdy=1.
REQ-014 Branch conditions SHALL be: beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bltz rs<0; bgez rs>=0, with all rs comparisons signed two's complement.
REQ-015 The branch target SHALL be i_pc4 + (sign-extend(i_imm)<<2), modulo 2^32 (wrap permitted).
REQ-016 The j/jal target SHALL be {i_pc4[31:28], i_jidx, 2'b00}.
REQ-017 The jr target SHALL be i_rs_val, with low two bits passed through unmodified.
REQ-018 The target SHALL be registered at resolution; o_target SHALL be stable and valid while o_redirect=1, and hold its last value otherwise.
REQ-019 In REDIRECT, the block SHALL assert o_redirect=1 for exactly one cycle, with o_if_stall=0, and return to IDLE; i_valid SHALL be ignored in this cycle.
REQ-020 Latency SHALL be: taken with ready operands -> redirect 1 cycle after acceptance; with N wait cycles -> N+1.
REQ-021 o_busy SHALL be 1 whenever the state is not IDLE.
REQ-022 While in WAIT_OPND, the block SHALL accept no new instruction; decode inputs are held by the stall.

Reset
REQ-023 When i_rst_n=0 at a rising edge, the block SHALL enter IDLE and clear o_redirect, o_id_flush, o_target and o_stall_cnt to 0; o_if_stall and o_busy SHALL be 0.
REQ-024 Reset in any state, including mid WAIT_OPND or REDIRECT, SHALL abandon the pending redirect with no pulse issued.

Configuration
REQ-025 With macro BRANCH_DELAY_SLOT_EN defined, the block SHALL keep o_id_flush at 0 so the delay-slot instruction completes.
REQ-026 Without BRANCH_DELAY_SLOT_EN, the block SHALL assert o_id_flush=1 exactly in the REDIRECT cycle.

Verification
REQ-027 The bench SHALL cover: beq, rs=rt=5, rdy=1, pc4=0x100, imm=0x0004 -> redirect next cycle, target 0x110; flush=1 only without the macro.
REQ-028 The bench SHALL cover: bgtz, rs=0x80000000 -> not taken; no redirect; FSM stays IDLE.
REQ-029 The bench SHALL cover: bne, rdy low 3 cycles -> if_stall high 3 cycles, stall_cnt=3, redirect on cycle 4.
REQ-030 The bench SHALL cover: j, pc4=0xA0000004, jidx=0x0000010 -> target 0xA0000040.
REQ-031 The bench SHALL cover: beq, pc4=0xFFFFFFFC, imm=0x0002 -> target 0x00000004 (wrap).
REQ-032 The bench SHALL cover: jr, rdy low, i_rst_n=0 during WAIT_OPND -> no redirect; all outputs 0 next cycle.
